// File: rtl/fma_pkg.sv
// fma_pkg: shared definitions for the single-precision FMA datapath.
//
// Contents:
//   PARM_EXP, PARM_MANT, PARM_BIAS, PARM_RM : binary32 field widths, bias, rm width
//   PARM_RM_*                               : rounding-mode encodings
//   OP_*                                    : FMA opcode encodings
//   PARM_MANT_NAN                           : quiet bit of the stored mantissa
//   fp_class_t                              : per-operand class flags
package fma_pkg;

  localparam int PARM_EXP  = 8;
  localparam int PARM_MANT = 23;
  localparam int PARM_BIAS = 127;
  localparam int PARM_RM   = 3;

  localparam logic [2:0] PARM_RM_RNE = 3'b000;
  localparam logic [2:0] PARM_RM_RTZ = 3'b001;
  localparam logic [2:0] PARM_RM_RDN = 3'b010;
  localparam logic [2:0] PARM_RM_RUP = 3'b011;
  localparam logic [2:0] PARM_RM_RMM = 3'b100;
  localparam logic [2:0] PARM_RM_DYN = 3'b111;

  localparam logic [1:0] OP_FMADD  = 2'b00;
  localparam logic [1:0] OP_FMSUB  = 2'b01;
  localparam logic [1:0] OP_FNMSUB = 2'b10;
  localparam logic [1:0] OP_FNMADD = 2'b11;

  localparam logic [PARM_MANT-1:0] PARM_MANT_NAN = 23'h400000;

  typedef struct packed {
    logic inf;
    logic zero;
    logic nan;
    logic snan;
    logic den;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational decode of one raw binary32 operand.
//
// Ports:
//   operand  in  32  raw IEEE-754 binary32 value
//   cls      out     class flags {inf, zero, nan, snan, den}
//   mant     out 24  mantissa with hidden bit
//   e_eff    out  8  effective exponent (1 for denormals, 0 for zero)
//   flushed  out  1  denormal was flushed to zero (only with FMA_UNPACK_DENORM_FLUSH_EN)
//
// Build option: FMA_UNPACK_DENORM_FLUSH_EN flushes denormal inputs to signed zero.
module fp_classify
  import fma_pkg::*;
(
  input  logic [PARM_EXP+PARM_MANT:0] operand,
  output fp_class_t                   cls,
  output logic [PARM_MANT:0]          mant,
  output logic [PARM_EXP-1:0]         e_eff
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
  , output logic                      flushed
`endif
);

  logic [PARM_EXP-1:0]  e;
  logic [PARM_MANT-1:0] f;
  logic                 e_zero;
  logic                 e_max;
  logic                 f_zero;
  logic                 is_den;

  assign e      = operand[PARM_EXP+PARM_MANT-1 -: PARM_EXP];
  assign f      = operand[PARM_MANT-1:0];
  assign e_zero = (e == '0);
  assign e_max  = &e;
  assign f_zero = (f == '0);
  assign is_den = e_zero & ~f_zero;

  assign cls.inf  = e_max & f_zero;
  assign cls.nan  = e_max & ~f_zero;
  // A NaN is signalling when the quiet bit of the mantissa is clear.
  assign cls.snan = e_max & ~f_zero & ((f & PARM_MANT_NAN) == '0);

`ifdef FMA_UNPACK_DENORM_FLUSH_EN
  // Denormals become signed zero: any zero exponent reads as zero.
  assign flushed  = is_den;
  assign cls.zero = e_zero;
  assign cls.den  = 1'b0;
  assign mant     = e_zero ? '0 : {1'b1, f};
  assign e_eff    = e;
`else
  assign cls.zero = e_zero & f_zero;
  assign cls.den  = is_den;
  assign mant     = {~e_zero, f};
  // Denormals share the scale of exponent 1; true zero keeps 0.
  assign e_eff    = is_den ? PARM_EXP'(1) : e;
`endif

endmodule

// File: rtl/fma_operand_unpack.sv
// fma_operand_unpack: front-end decode stage of the single-precision FMA.
//
// Two-stage valid/ready pipeline. S1 captures the raw operands, opcode and
// resolved rounding mode; S2 captures the decoded fields and drives every
// data output straight from flops.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   Valid_i / Ready_o             upstream handshake
//   A_i, B_i, C_i                 raw operands (A addend, B*C product)
//   Op_i                          00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
//   Rm_i, Frm_i                   instruction rounding mode (111 = dynamic), fcsr.frm
//   Valid_o / Ready_i             downstream handshake
//   X_Sign_o, X_Exp_raw_o, X_Mant_o   effective sign, stored exponent, mantissa
//   Exp_prod_o                    signed B*C exponent Eb_eff + Ec_eff - bias
//   X_Inf/Zero/NaN/SNaN/DeN_o     class flags
//   Sub_Sign_o                    effective subtraction
//   Rounding_mode_o, Rm_illegal_o resolved mode and its legality
//   Denorm_flushed_o              any operand flushed (only with FMA_UNPACK_DENORM_FLUSH_EN)
//
// Build option: FMA_UNPACK_DENORM_FLUSH_EN flushes denormal inputs to signed zero.
module fma_operand_unpack #(
  parameter int PARM_EXP  = fma_pkg::PARM_EXP,
  parameter int PARM_MANT = fma_pkg::PARM_MANT,
  parameter int PARM_BIAS = fma_pkg::PARM_BIAS,
  parameter int PARM_RM   = fma_pkg::PARM_RM
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      Valid_i,
  output logic                      Ready_o,
  input  logic [PARM_EXP+PARM_MANT:0] A_i,
  input  logic [PARM_EXP+PARM_MANT:0] B_i,
  input  logic [PARM_EXP+PARM_MANT:0] C_i,
  input  logic [1:0]                Op_i,
  input  logic [PARM_RM-1:0]        Rm_i,
  input  logic [PARM_RM-1:0]        Frm_i,
  output logic                      Valid_o,
  input  logic                      Ready_i,
  output logic                      A_Sign_o,
  output logic                      B_Sign_o,
  output logic                      C_Sign_o,
  output logic [PARM_EXP-1:0]       A_Exp_raw_o,
  output logic [PARM_EXP-1:0]       B_Exp_raw_o,
  output logic [PARM_EXP-1:0]       C_Exp_raw_o,
  output logic [PARM_MANT:0]        A_Mant_o,
  output logic [PARM_MANT:0]        B_Mant_o,
  output logic [PARM_MANT:0]        C_Mant_o,
  output logic [PARM_EXP+1:0]       Exp_prod_o,
  output logic                      A_Inf_o,
  output logic                      A_Zero_o,
  output logic                      A_NaN_o,
  output logic                      A_SNaN_o,
  output logic                      A_DeN_o,
  output logic                      B_Inf_o,
  output logic                      B_Zero_o,
  output logic                      B_NaN_o,
  output logic                      B_SNaN_o,
  output logic                      B_DeN_o,
  output logic                      C_Inf_o,
  output logic                      C_Zero_o,
  output logic                      C_NaN_o,
  output logic                      C_SNaN_o,
  output logic                      C_DeN_o,
  output logic                      Sub_Sign_o,
  output logic [PARM_RM-1:0]        Rounding_mode_o,
  output logic                      Rm_illegal_o
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
  , output logic                    Denorm_flushed_o
`endif
);

  localparam int W   = 1 + PARM_EXP + PARM_MANT;
  localparam int EPW = PARM_EXP + 2;

  // ---------------- handshake ----------------
  logic v1;
  logic v2;
  logic load1;
  logic load2;

  assign load2   = ~v2 | Ready_i;
  assign load1   = ~v1 | load2;
  assign Ready_o = load1;
  assign Valid_o = v2;

  // ---------------- stage 1 ----------------
  logic [W-1:0]       a1;
  logic [W-1:0]       b1;
  logic [W-1:0]       c1;
  logic [1:0]         op1;
  logic [PARM_RM-1:0] rm1;
  logic [PARM_RM-1:0] rm_res;

  assign rm_res = (Rm_i == PARM_RM'(fma_pkg::PARM_RM_DYN)) ? Frm_i : Rm_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      c1  <= '0;
      op1 <= '0;
      rm1 <= '0;
    end else if (load1) begin
      v1 <= Valid_i;
      if (Valid_i) begin
        a1  <= A_i;
        b1  <= B_i;
        c1  <= C_i;
        op1 <= Op_i;
        rm1 <= rm_res;
      end
    end
  end

  // ---------------- decode between S1 and S2 ----------------
  logic [W-1:0]          opnd    [3];
  fma_pkg::fp_class_t    cls     [3];
  logic [PARM_MANT:0]    mant    [3];
  logic [PARM_EXP-1:0]   eeff    [3];
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
  logic                  flushed [3];
`endif

  assign opnd[0] = a1;
  assign opnd[1] = b1;
  assign opnd[2] = c1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cls
    fp_classify u_cls (
      .operand (opnd[gi]),
      .cls     (cls[gi]),
      .mant    (mant[gi]),
      .e_eff   (eeff[gi])
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
      , .flushed (flushed[gi])
`endif
    );
  end

  logic           prod_sign;
  logic           a_sign;
  logic [EPW-1:0] exp_prod;

  // Op[1] negates the product; Op[0] negates the addend (FMSUB, FNMADD).
  assign prod_sign = b1[W-1] ^ c1[W-1] ^ op1[1];
  assign a_sign    = a1[W-1] ^ op1[0];

  // Wraps naturally in EPW bits: the full range fits in two's complement.
  assign exp_prod = (cls[1].zero | cls[2].zero) ? '0 :
                    EPW'(eeff[1]) + EPW'(eeff[2]) - EPW'(PARM_BIAS);

  // ---------------- stage 2 ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v2 <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      A_Sign_o        <= 1'b0;
      B_Sign_o        <= 1'b0;
      C_Sign_o        <= 1'b0;
      A_Exp_raw_o     <= '0;
      B_Exp_raw_o     <= '0;
      C_Exp_raw_o     <= '0;
      A_Mant_o        <= '0;
      B_Mant_o        <= '0;
      C_Mant_o        <= '0;
      Exp_prod_o      <= '0;
      {A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o, A_DeN_o} <= '0;
      {B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o, B_DeN_o} <= '0;
      {C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o, C_DeN_o} <= '0;
      Sub_Sign_o      <= 1'b0;
      Rounding_mode_o <= '0;
      Rm_illegal_o    <= 1'b0;
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
      Denorm_flushed_o <= 1'b0;
`endif
    end else if (load2 && v1) begin
      A_Sign_o        <= a_sign;
      B_Sign_o        <= prod_sign;
      C_Sign_o        <= c1[W-1];
      A_Exp_raw_o     <= a1[W-2 -: PARM_EXP];
      B_Exp_raw_o     <= b1[W-2 -: PARM_EXP];
      C_Exp_raw_o     <= c1[W-2 -: PARM_EXP];
      A_Mant_o        <= mant[0];
      B_Mant_o        <= mant[1];
      C_Mant_o        <= mant[2];
      Exp_prod_o      <= exp_prod;
      {A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o, A_DeN_o} <= cls[0];
      {B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o, B_DeN_o} <= cls[1];
      {C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o, C_DeN_o} <= cls[2];
      Sub_Sign_o      <= prod_sign ^ a_sign;
      Rounding_mode_o <= rm1;
      // Encodings above RMM (101, 110, 111) are reserved.
      Rm_illegal_o    <= (rm1 > PARM_RM'(fma_pkg::PARM_RM_RMM));
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
      Denorm_flushed_o <= flushed[0] | flushed[1] | flushed[2];
`endif
    end
  end

endmodule

// File: tb/tb_fma_operand_unpack.sv
// Self-checking bench for fma_operand_unpack: directed vectors, a stall
// scenario, reset while full and a randomized stream, all scored against a
// behavioural model of the decode rules.
module tb_fma_operand_unpack;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        Valid_i, Ready_o, Valid_o, Ready_i;
  logic [31:0] A_i, B_i, C_i;
  logic [1:0]  Op_i;
  logic [2:0]  Rm_i, Frm_i;
  logic        A_Sign_o, B_Sign_o, C_Sign_o;
  logic [7:0]  A_Exp_raw_o, B_Exp_raw_o, C_Exp_raw_o;
  logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
  logic [9:0]  Exp_prod_o;
  logic        A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o, A_DeN_o;
  logic        B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o, B_DeN_o;
  logic        C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o, C_DeN_o;
  logic        Sub_Sign_o, Rm_illegal_o;
  logic [2:0]  Rounding_mode_o;
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
  logic        Denorm_flushed_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma_operand_unpack dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .Valid_i(Valid_i), .Ready_o(Ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i), .Op_i(Op_i), .Rm_i(Rm_i), .Frm_i(Frm_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i),
    .A_Sign_o(A_Sign_o), .B_Sign_o(B_Sign_o), .C_Sign_o(C_Sign_o),
    .A_Exp_raw_o(A_Exp_raw_o), .B_Exp_raw_o(B_Exp_raw_o), .C_Exp_raw_o(C_Exp_raw_o),
    .A_Mant_o(A_Mant_o), .B_Mant_o(B_Mant_o), .C_Mant_o(C_Mant_o),
    .Exp_prod_o(Exp_prod_o),
    .A_Inf_o(A_Inf_o), .A_Zero_o(A_Zero_o), .A_NaN_o(A_NaN_o), .A_SNaN_o(A_SNaN_o), .A_DeN_o(A_DeN_o),
    .B_Inf_o(B_Inf_o), .B_Zero_o(B_Zero_o), .B_NaN_o(B_NaN_o), .B_SNaN_o(B_SNaN_o), .B_DeN_o(B_DeN_o),
    .C_Inf_o(C_Inf_o), .C_Zero_o(C_Zero_o), .C_NaN_o(C_NaN_o), .C_SNaN_o(C_SNaN_o), .C_DeN_o(C_DeN_o),
    .Sub_Sign_o(Sub_Sign_o), .Rounding_mode_o(Rounding_mode_o), .Rm_illegal_o(Rm_illegal_o)
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
    , .Denorm_flushed_o(Denorm_flushed_o)
`endif
  );

  // Flags are ordered {inf, zero, nan, snan, den}.
  typedef struct packed {
    logic        as, bs, cs;
    logic [7:0]  ae, be, ce;
    logic [23:0] am, bm, cm;
    logic [9:0]  ep;
    logic [4:0]  af, bf, cf;
    logic        sub;
    logic [2:0]  rm;
    logic        ill;
    logic        fl;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  // ---------------- reference model ----------------
  function automatic void cls_ref(input logic [31:0] x, output logic [4:0] flags,
                                  output logic [23:0] m, output logic flushed);
    int  e, f;
    logic inf, zero, nan, snan, den;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    zero = (e == 0) && (f == 0);
    den  = (e == 0) && (f != 0);
    inf  = (e == 255) && (f == 0);
    nan  = (e == 255) && (f != 0);
    snan = nan && (f < 'h400000);
    m    = 24'((e != 0) ? f + (1 << 23) : f);
    flushed = 1'b0;
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
    if (den) begin
      zero = 1'b1; den = 1'b0; m = '0; flushed = 1'b1;
    end
`endif
    flags = {inf, zero, nan, snan, den};
  endfunction

  function automatic int eeff_ref(input logic [31:0] x);
    int e, f;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
    return e;
`else
    if (e == 0) return (f != 0) ? 1 : 0;
    return e;
`endif
  endfunction

  function automatic beat_t model(input logic [31:0] a, b, c, input logic [1:0] op,
                                  input logic [2:0] rm, frm);
    beat_t r;
    logic fa, fb, fc, prod_neg, a_neg;
    logic [2:0] rmres;
    int ep;
    cls_ref(a, r.af, r.am, fa);
    cls_ref(b, r.bf, r.bm, fb);
    cls_ref(c, r.cf, r.cm, fc);
    r.ae = a[30:23]; r.be = b[30:23]; r.ce = c[30:23];
    // FMADD b*c+a, FMSUB b*c-a, FNMSUB -(b*c)+a, FNMADD -(b*c)-a
    prod_neg = b[31] ^ c[31] ^ (op == 2'd2 || op == 2'd3);
    a_neg    = a[31] ^ (op == 2'd1 || op == 2'd3);
    r.as = a_neg; r.bs = prod_neg; r.cs = c[31];
    r.sub = (prod_neg != a_neg);
    ep = (r.bf[3] || r.cf[3]) ? 0 : eeff_ref(b) + eeff_ref(c) - 127;
    r.ep = 10'(ep);
    rmres = (rm == 3'd7) ? frm : rm;
    r.rm  = rmres;
    r.ill = (rmres >= 3'd5);
    r.fl  = fa | fb | fc;
    return r;
  endfunction

  function automatic beat_t snap();
    beat_t s;
    s.as = A_Sign_o; s.bs = B_Sign_o; s.cs = C_Sign_o;
    s.ae = A_Exp_raw_o; s.be = B_Exp_raw_o; s.ce = C_Exp_raw_o;
    s.am = A_Mant_o; s.bm = B_Mant_o; s.cm = C_Mant_o;
    s.ep = Exp_prod_o;
    s.af = {A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o, A_DeN_o};
    s.bf = {B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o, B_DeN_o};
    s.cf = {C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o, C_DeN_o};
    s.sub = Sub_Sign_o; s.rm = Rounding_mode_o; s.ill = Rm_illegal_o;
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
    s.fl = Denorm_flushed_o;
`else
    s.fl = 1'b0;
`endif
    return s;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 3))
      0:       f = '0;
      1:       f = 23'h400000 | 23'($urandom_range(0, 3));
      2:       f = 23'($urandom_range(1, 7));
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, log transfers
  // that the coming posedge will perform.
  task automatic tick(input logic vi, input logic [31:0] a, b, c, input logic [1:0] op,
                      input logic [2:0] rm, frm, input logic ri,
                      output logic acc, output logic rdy);
    @(negedge clk);
    Valid_i = vi; A_i = a; B_i = b; C_i = c; Op_i = op; Rm_i = rm; Frm_i = frm;
    Ready_i = ri;
    #1;
    rdy = Ready_o;
    acc = vi && Ready_o;
    if (acc) exp_q.push_back(model(a, b, c, op, rm, frm));
    if (Valid_o && Ready_i) obs_q.push_back(snap());
  endtask

  task automatic drain(input string name);
    logic acc, rdy;
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 40) begin
      tick(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
      n++;
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; Valid_i = 1'b0; Ready_i = 1'b0;
    A_i = '0; B_i = '0; C_i = '0; Op_i = '0; Rm_i = '0; Frm_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++;
    if ({Valid_o, Ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake got valid=%b ready=%b required valid=0 ready=1", Valid_o, Ready_o);
    end
    checks++;
    if (snap() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", snap());
    end
    $display("reset: valid=%b ready=%b", Valid_o, Ready_o);
  endtask

  task automatic test_directed();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] vc [10];
    logic [1:0]  vop [10];
    logic [2:0]  vrm [10];
    logic [2:0]  vfrm [10];
    logic acc, rdy;
    beat_t o, e;
    int i;
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 10; k++) begin
      va[k] = 32'h3F800000; vb[k] = 32'h40000000; vc[k] = 32'h40400000;
      vop[k] = 2'b00; vrm[k] = 3'b000; vfrm[k] = 3'b000;
    end
    vop[1] = 2'b01;
    vop[2] = 2'b11;
    vb[3]  = 32'h00000001;
    va[4]  = 32'h7F800001;
    va[5]  = 32'h7FC00000;
    vc[6]  = 32'h7F800000;
    vrm[7] = 3'b111; vfrm[7] = 3'b010;
    vrm[8] = 3'b111; vfrm[8] = 3'b101;
    vrm[9] = 3'b110;
    i = 0;
    while (i < 10) begin
      tick(1'b1, va[i], vb[i], vc[i], vop[i], vrm[i], vfrm[i], 1'b1, acc, rdy);
      if (acc) i++;
    end
    drain("directed");
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      o = obs_q[k]; e = exp_q[k];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL directed_model[%0d] got %h required %h", k, o, e);
      end
      $display("directed beat %0d: ep=%0d flags=%b/%b/%b sub=%b rm=%0d ill=%b", k,
               $signed(o.ep), o.af, o.bf, o.cf, o.sub, o.rm, o.ill);
    end
    if (obs_q.size() == 10) begin
      o = obs_q[0];
      checks++;
      if ({o.bm, o.cm, o.ep, o.sub, o.af, o.bf, o.cf} !== {24'h800000, 24'hC00000, 10'd129, 1'b0, 15'd0}) begin
        errors++;
        $display("FAIL basic_fmadd got bm=%h cm=%h ep=%0d sub=%b required 800000 C00000 129 0", o.bm, o.cm, o.ep, o.sub);
      end
      o = obs_q[1];
      checks++;
      if ({o.as, o.sub} !== 2'b11) begin
        errors++;
        $display("FAIL fmsub_sign got as=%b sub=%b required 1 1", o.as, o.sub);
      end
      o = obs_q[2];
      checks++;
      if ({o.bs, o.as, o.sub} !== 3'b110) begin
        errors++;
        $display("FAIL fnmadd_sign got bs=%b as=%b sub=%b required 1 1 0", o.bs, o.as, o.sub);
      end
      o = obs_q[3];
      checks++;
`ifdef FMA_UNPACK_DENORM_FLUSH_EN
      if ({o.bf, o.bm, o.ep, o.fl} !== {5'b01000, 24'h0, 10'd0, 1'b1}) begin
        errors++;
        $display("FAIL denorm_flush got bf=%b bm=%h ep=%0d fl=%b required 01000 0 0 1", o.bf, o.bm, o.ep, o.fl);
      end
`else
      if ({o.bf, o.bm, o.ep} !== {5'b00001, 24'h000001, 10'd2}) begin
        errors++;
        $display("FAIL denorm_pass got bf=%b bm=%h ep=%0d required 00001 000001 2", o.bf, o.bm, o.ep);
      end
`endif
      checks++;
      if ({obs_q[4].af, obs_q[5].af, obs_q[6].cf} !== {5'b00110, 5'b00100, 5'b10000}) begin
        errors++;
        $display("FAIL nan_inf_class got %b %b %b required 00110 00100 10000", obs_q[4].af, obs_q[5].af, obs_q[6].cf);
      end
      checks++;
      if ({obs_q[7].rm, obs_q[7].ill, obs_q[8].rm, obs_q[8].ill, obs_q[9].rm, obs_q[9].ill}
          !== {3'd2, 1'b0, 3'd5, 1'b1, 3'd6, 1'b1}) begin
        errors++;
        $display("FAIL rounding_mode got %0d/%b %0d/%b %0d/%b required 2/0 5/1 6/1",
                 obs_q[7].rm, obs_q[7].ill, obs_q[8].rm, obs_q[8].ill, obs_q[9].rm, obs_q[9].ill);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic acc, rdy;
    beat_t held;
    int k = 0;
    exp_q.delete(); obs_q.delete();
    for (int j = 0; j < 4; j++) begin
      sa[j] = 32'h3F800000 + 32'(j);
      sb[j] = 32'h40000000 + 32'(j << 23);
    end
    for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
      tick(k < 4, sa[k % 4], sb[k % 4], 32'h40400000, 2'(k), 3'd0, 3'd0, cyc >= 4, acc, rdy);
      if (acc) k++;
      if (cyc == 2) begin
        held = snap();
        checks++;
        if ({rdy, Valid_o} !== 2'b01) begin
          errors++;
          $display("FAIL stall_full got ready=%b valid=%b required ready=0 valid=1", rdy, Valid_o);
        end
      end
      if (cyc == 3) begin
        checks++;
        if ({rdy, Valid_o, snap()} !== {2'b01, held}) begin
          errors++;
          $display("FAIL stall_hold got ready=%b %h required ready=0 %h", rdy, snap(), held);
        end
      end
    end
    drain("stall");
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL stall_order[%0d] got %h required %h", j, obs_q[j], exp_q[j]);
      end
      $display("stall beat %0d: am=%h be=%h", j, obs_q[j].am, obs_q[j].be);
    end
  endtask

  task automatic test_reset_full();
    logic acc, rdy;
    exp_q.delete(); obs_q.delete();
    repeat (3) tick(1'b1, rand_op(), rand_op(), rand_op(), 2'($urandom), 3'($urandom), 3'($urandom), 1'b0, acc, rdy);
    @(negedge clk);
    rst_ni = 1'b0; Valid_i = 1'b0; Ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({Valid_o, snap()} !== '0) begin
      errors++;
      $display("FAIL reset_full got valid=%b %h required 0", Valid_o, snap());
    end
    @(negedge clk);
    rst_ni = 1'b1;
    exp_q.delete(); obs_q.delete();
    repeat (5) tick(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_discard got %0d beats required 0", obs_q.size());
    end
    $display("reset while full: valid=%b beats after=%0d", Valid_o, obs_q.size());
  endtask

  task automatic test_random();
    logic acc, rdy;
    exp_q.delete(); obs_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick($urandom_range(0, 9) < 7, rand_op(), rand_op(), rand_op(), 2'($urandom),
           3'($urandom), 3'($urandom), $urandom_range(0, 9) < 6, acc, rdy);
    end
    drain("random");
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL random[%0d] got %h required %h", j, obs_q[j], exp_q[j]);
      end
      $display("random beat %0d: ep=%0d sub=%b rm=%0d", j, $signed(obs_q[j].ep), obs_q[j].sub, obs_q[j].rm);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_stall();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
